// File: rtl/dphy_lprx_multilane.sv
// Multi-lane D-PHY low-power receiver.
// Each lane synchronises and run-length filters its {Dp,Dn} comparator pair.
// It then follows the LP state sequence to enable the HS receiver after the
// termination delay, or to enter Escape mode, and it flags illegal sequences.
// Lanes share only the clock, the reset and the global enable.
//
// Handshake note: this block has no valid/ready interfaces. Every output is a
// registered level or pulse, and it updates on the rising edge of LPRX_CLK.
module dphy_lprx_multilane #(
  parameter int NUM_LANES      = 4,
  parameter int D_TERM_EN_TIME = 6,
  parameter int FILTER_LEN     = 2
) (
  input  logic                 LPRX_CLK,
  input  logic                 RxRst_n,
  input  logic                 LPEnable,
  input  logic [NUM_LANES-1:0] LP_Dp,
  input  logic [NUM_LANES-1:0] LP_Dn,
  output logic [NUM_LANES-1:0] HSRX_EN,
  output logic [NUM_LANES-1:0] ESC_EN,
  output logic [NUM_LANES-1:0] STOP_STATE,
  output logic [NUM_LANES-1:0] LP_ERR,
  output logic                 ALL_HSRX_EN
);

  localparam int CNT_W = $clog2(D_TERM_EN_TIME + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(D_TERM_EN_TIME);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(FILTER_LEN);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);

  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;

  localparam logic [2:0] S_WAIT_STOP  = 3'd0;
  localparam logic [2:0] S_STOP       = 3'd1;
  localparam logic [2:0] S_HS_RQST    = 3'd2;
  localparam logic [2:0] S_HS_PREP    = 3'd3;
  localparam logic [2:0] S_HS_ACTIVE  = 3'd4;
  localparam logic [2:0] S_ESC_RQST   = 3'd5;
  localparam logic [2:0] S_ESC_BRIDGE = 3'd6;
  localparam logic [2:0] S_ESC_ACK    = 3'd7;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       last_q;
    logic [FLT_W-1:0] run_q, run_d;
    logic [1:0]       filt_q, filt_d;
    logic [2:0]       state_q, state_d;
    logic             esc_act_q, esc_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             hsrx_q, esc_q, stop_q, err_q;

    // Two-flop synchroniser for the asynchronous comparator pair.
    always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
      if (!RxRst_n) begin
        sync1_q <= LP11;
        sync2_q <= LP11;
      end else begin
        sync1_q <= {LP_Dp[g], LP_Dn[g]};
        sync2_q <= sync1_q;
      end
    end

    // Run-length filter: accept a value once it has been seen on FILTER_LEN edges in a row.
    always_comb begin
      run_d = FLT_ONE;
      if (sync2_q == last_q) begin
        run_d = (run_q == FLT_MAX) ? run_q : run_q + FLT_ONE;
      end
      filt_d = (run_d == FLT_MAX) ? sync2_q : filt_q;
    end

    // Filter history and accepted LP state.
    always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
      if (!RxRst_n) begin
        last_q <= LP11;
        run_q  <= '0;
        filt_q <= LP11;
      end else begin
        last_q <= sync2_q;
        run_q  <= run_d;
        filt_q <= filt_d;
      end
    end

    // Lane FSM. It acts on the value the filter accepts at this same edge.
    // ESC_ACTIVE is held as a separate flag, so all nine states fit in 3 bits plus the flag.
    always_comb begin
      state_d   = state_q;
      esc_act_d = esc_act_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      if (!LPEnable) begin
        state_d   = S_WAIT_STOP;
        esc_act_d = 1'b0;
        cnt_d     = '0;
      end else if (esc_act_q) begin
        if (filt_d == LP11) begin
          state_d   = S_STOP;
          esc_act_d = 1'b0;
        end
      end else begin
        case (state_q)
          S_WAIT_STOP: begin
            if (filt_d == LP11) state_d = S_STOP;
          end
          S_STOP: begin
            case (filt_d)
              LP01:    state_d = S_HS_RQST;
              LP10:    state_d = S_ESC_RQST;
              LP00:    begin state_d = S_WAIT_STOP; err_d = 1'b1; end
              default: state_d = S_STOP;
            endcase
          end
          S_HS_RQST: begin
            case (filt_d)
              LP00:    begin state_d = S_HS_PREP; cnt_d = '0; end
              LP11:    state_d = S_STOP;
              LP10:    begin state_d = S_WAIT_STOP; err_d = 1'b1; end
              default: state_d = S_HS_RQST;
            endcase
          end
          S_HS_PREP: begin
            case (filt_d)
              LP00: begin
                if (cnt_q != TERM_CNT) cnt_d = cnt_q + CNT_ONE;
                if (cnt_d == TERM_CNT) state_d = S_HS_ACTIVE;
              end
              LP11:    begin state_d = S_STOP; cnt_d = '0; end
              default: begin state_d = S_WAIT_STOP; cnt_d = '0; err_d = 1'b1; end
            endcase
          end
          S_HS_ACTIVE: begin
            if (filt_d == LP11) begin
              state_d = S_STOP;
              cnt_d   = '0;
            end
          end
          S_ESC_RQST: begin
            case (filt_d)
              LP00:    state_d = S_ESC_BRIDGE;
              LP11:    state_d = S_STOP;
              LP01:    begin state_d = S_WAIT_STOP; err_d = 1'b1; end
              default: state_d = S_ESC_RQST;
            endcase
          end
          S_ESC_BRIDGE: begin
            case (filt_d)
              LP01:    state_d = S_ESC_ACK;
              LP11:    state_d = S_STOP;
              LP10:    begin state_d = S_WAIT_STOP; err_d = 1'b1; end
              default: state_d = S_ESC_BRIDGE;
            endcase
          end
          S_ESC_ACK: begin
            case (filt_d)
              LP00:    esc_act_d = 1'b1;
              LP11:    state_d = S_STOP;
              LP10:    begin state_d = S_WAIT_STOP; err_d = 1'b1; end
              default: state_d = S_ESC_ACK;
            endcase
          end
          default: state_d = S_WAIT_STOP;
        endcase
      end
    end

    // FSM state plus outputs. The outputs are registered from the next state, so they track the state exactly.
    always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
      if (!RxRst_n) begin
        state_q   <= S_WAIT_STOP;
        esc_act_q <= 1'b0;
        cnt_q     <= '0;
        hsrx_q    <= 1'b0;
        esc_q     <= 1'b0;
        stop_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        esc_act_q <= esc_act_d;
        cnt_q     <= cnt_d;
        hsrx_q    <= (state_d == S_HS_ACTIVE) && !esc_act_d;
        esc_q     <= esc_act_d;
        stop_q    <= (state_d == S_STOP) && !esc_act_d;
        err_q     <= err_d;
      end
    end

    assign HSRX_EN[g]    = hsrx_q;
    assign ESC_EN[g]     = esc_q;
    assign STOP_STATE[g] = stop_q;
    assign LP_ERR[g]     = err_q;
  end

  assign ALL_HSRX_EN = &HSRX_EN;

endmodule

// File: tb/tb_dphy_lprx_multilane.sv
// Directed bench for dphy_lprx_multilane with two lanes.
// A table of {lane inputs, hold cycles, expected outputs} drives most of the run.
// Hand-written sequences then cover reset and LPEnable interruptions.
module tb_dphy_lprx_multilane;
  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NL-1:0] dp, dn;
  logic [NL-1:0] hsrx_en, esc_en, stop_state, lp_err;
  logic          all_hsrx_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] l0;
    logic [1:0] l1;
    logic       en;
    int         cyc;
    logic [1:0] hs;
    logic [1:0] esc;
    logic [1:0] stop;
    logic [1:0] err;
    logic       all_hs;
  } vec_t;

  vec_t tbl[$];

  // ---------------- clock / reset block
  always #50 clk = ~clk;

  dphy_lprx_multilane #(
    .NUM_LANES(NL),
    .D_TERM_EN_TIME(6),
    .FILTER_LEN(2)
  ) dut (
    .LPRX_CLK   (clk),
    .RxRst_n    (rst_n),
    .LPEnable   (en),
    .LP_Dp      (dp),
    .LP_Dn      (dn),
    .HSRX_EN    (hsrx_en),
    .ESC_EN     (esc_en),
    .STOP_STATE (stop_state),
    .LP_ERR     (lp_err),
    .ALL_HSRX_EN(all_hsrx_en)
  );

  // ---------------- driver tasks
  task automatic drive(input logic [1:0] l0, input logic [1:0] l1, input logic e);
    dp = {l1[1], l0[1]};
    dn = {l1[0], l0[0]};
    en = e;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] l0, input logic [1:0] l1, input int cyc,
                     input logic [1:0] hs, input logic [1:0] esc,
                     input logic [1:0] stop, input logic [1:0] err, input logic all_hs);
    vec_t v;
    v.l0 = l0; v.l1 = l1; v.en = 1'b1; v.cyc = cyc;
    v.hs = hs; v.esc = esc; v.stop = stop; v.err = err; v.all_hs = all_hs;
    tbl.push_back(v);
  endtask

  // ---------------- scoreboard
  task automatic cmp2(input string nm, input string sig, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %b expected %b", nm, sig, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [1:0] hs, input logic [1:0] esc,
                           input logic [1:0] stop, input logic [1:0] err, input logic all_hs);
    cmp2(nm, "HSRX_EN", hsrx_en, hs);
    cmp2(nm, "ESC_EN", esc_en, esc);
    cmp2(nm, "STOP_STATE", stop_state, stop);
    cmp2(nm, "LP_ERR", lp_err, err);
    cmp2(nm, "ALL_HSRX_EN", {1'b0, all_hsrx_en}, {1'b0, all_hs});
  endtask

  initial begin
    // Each vector holds its inputs for cyc edges; an input change shows at the outputs 4 edges later.
    // l0 l1 cyc   hs     esc    stop   err    all
    // HS entry on lane 0
    add(2'b11, 2'b11, 10, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b01, 2'b11,  3, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b01, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b01, 2'b11,  6, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  3, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  1, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11, 20, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b10, 2'b11,  6, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  3, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    // HS entry on both lanes
    add(2'b01, 2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(2'b00, 2'b00,  9, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(2'b00, 2'b00,  1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    add(2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    // Escape entry on lane 1
    add(2'b11, 2'b10,  5, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b00,  5, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b01,  5, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b00,  3, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b00,  1, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b01,  5, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b10,  5, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b11,  3, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    // One-cycle glitch is discarded; a two-cycle 01 gives an HS request that 11 aborts
    add(2'b01, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b01, 2'b11,  2, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b11, 2'b11,  2, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    // Illegal 01 -> 10, then illegal 11 -> 00
    add(2'b01, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b10, 2'b11,  3, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b10, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0);
    add(2'b10, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b10, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  3, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b00, 2'b11,  3, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b00, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0);
    add(2'b00, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    // Illegal 01 during HS_PREP, then an HS_PREP abort by 11
    add(2'b01, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b01, 2'b11,  4, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0);
    add(2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    add(2'b01, 2'b11,  5, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b00, 2'b11,  6, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    add(2'b11, 2'b11,  4, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);

    // Reset state
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 1'b0);
    step(5);
    check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Enable with both lanes idle at 11
    rst_n = 1'b1;
    en    = 1'b1;
    step(4);
    check_all("stop_entry", 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].l0, tbl[i].l1, tbl[i].en);
      step(tbl[i].cyc);
      check_all($sformatf("vec%0d", i), tbl[i].hs, tbl[i].esc, tbl[i].stop, tbl[i].err, tbl[i].all_hs);
    end

    // Reset asserted in HS_ACTIVE clears the outputs before the next edge
    drive(2'b01, 2'b01, 1'b1);
    step(10);
    drive(2'b00, 2'b00, 1'b1);
    step(10);
    check_all("hs_both", 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    #20;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    drive(2'b11, 2'b11, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(4);
    check_all("post_rst", 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);

    // LPEnable dropped in ESC_ACTIVE
    drive(2'b11, 2'b10, 1'b1); step(5);
    drive(2'b11, 2'b00, 1'b1); step(5);
    drive(2'b11, 2'b01, 1'b1); step(5);
    drive(2'b11, 2'b00, 1'b1); step(5);
    check_all("esc_active", 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    step(1);
    check_all("lpen_off", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step(3);
    check_all("lpen_off_hold", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b1);
    step(1);
    check_all("lpen_on", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    // An HS request before any accepted 11 is ignored
    drive(2'b11, 2'b01, 1'b1); step(10);
    drive(2'b11, 2'b00, 1'b1); step(10);
    check_all("no_hs_wo_stop", 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    drive(2'b11, 2'b11, 1'b1); step(4);
    check_all("restop", 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b01, 1'b1); step(10);
    drive(2'b11, 2'b00, 1'b1); step(10);
    check_all("hs_after_stop", 2'b10, 2'b00, 2'b01, 2'b00, 1'b0);
    drive(2'b11, 2'b11, 1'b1); step(4);
    check_all("final_stop", 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dphy_lprx_multilane.md
Name: dphy_lprx_multilane

Overview:
- Parametrised, multi-lane successor to the single-lane D-PHY low-power receiver.
- Each lane synchronises and deglitches its LP_Dp/LP_Dn pair, then tracks the LP state sequence to detect HS-request entry and Escape-mode entry.
- Per lane it raises HSRX_EN after the termination-enable delay, or ESC_EN, and flags illegal sequences.
- Sits between the LP comparators of each data lane and the HS receiver / escape decoder.

Parameters:
- NUM_LANES, 4, number of independent data lanes (1..8).
- D_TERM_EN_TIME, 6, LPRX_CLK cycles spent in HS_PREP before HSRX_EN asserts (>=1).
- FILTER_LEN, 2, consecutive identical synchronised samples required to accept a new LP state (>=1).

Ports:
- LPRX_CLK  in  1  LP receive clock; all logic on rising edge.
- RxRst_n  in  1  asynchronous active-low reset.
- LPEnable  in  1  global LP receiver enable.
- LP_Dp  in  NUM_LANES  per-lane LP Dp comparator output (asynchronous).
- LP_Dn  in  NUM_LANES  per-lane LP Dn comparator output (asynchronous).
- HSRX_EN  out  NUM_LANES  per-lane HS receiver / termination enable.
- ESC_EN  out  NUM_LANES  per-lane Escape mode active.
- STOP_STATE  out  NUM_LANES  per-lane lane is in Stop state (LP-11 accepted).
- LP_ERR  out  NUM_LANES  per-lane one-cycle pulse on illegal LP sequence.
- ALL_HSRX_EN  out  1  AND of all HSRX_EN bits (combinational from registers).

Behaviour:
- Reset (async, RxRst_n=0):
  - Sync flops and filtered state are set to LP-11.
  - FSM is set to WAIT_STOP; counters are cleared.
  - All outputs are 0.
- Input path per lane:
  - 2-flop synchroniser on {Dp,Dn}.
  - Filter: filtered state takes the synchroniser output at the edge where that output has been equal for FILTER_LEN consecutive edges, including that edge.
  - An input change sampled at edge k reaches the filtered state at edge k+1+FILTER_LEN.
  - Shorter pulses are discarded silently.
- FSM per lane, evaluated on the filtered state {Dp,Dn}:
  - WAIT_STOP: 11 -> STOP; otherwise stay. No error raised here.
  - STOP (STOP_STATE=1): 01 -> HS_RQST; 10 -> ESC_RQST; 00 -> LP_ERR, WAIT_STOP.
  - HS_RQST: 00 -> HS_PREP (counter cleared); 11 -> STOP (abort, no error); 10 -> LP_ERR, WAIT_STOP.
  - HS_PREP: counter +1 per edge while 00. When the counter reaches D_TERM_EN_TIME -> HS_ACTIVE with HSRX_EN=1 on that same edge, i.e. D_TERM_EN_TIME edges after HS_PREP entry. 11 -> STOP; 01/10 -> LP_ERR, WAIT_STOP.
  - HS_ACTIVE (HSRX_EN=1): LP-level 00/01/10 ignored (HS traffic); 11 -> STOP, HSRX_EN=0 on the same edge.
  - ESC_RQST (10): 00 -> ESC_BRIDGE; 11 -> STOP; 01 -> LP_ERR, WAIT_STOP.
  - ESC_BRIDGE (00): 01 -> ESC_ACK; 11 -> STOP; 10 -> LP_ERR, WAIT_STOP.
  - ESC_ACK (01): 00 -> ESC_ACTIVE with ESC_EN=1; 11 -> STOP; 10 -> LP_ERR, WAIT_STOP.
  - ESC_ACTIVE (ESC_EN=1): 11 -> STOP with ESC_EN=0; all other states ignored.
- Outputs are registered and decoded from the state.
- LP_ERR is high for exactly the one cycle following the offending transition edge.
- HSRX_EN and ESC_EN are never high together.
- LPEnable=0: every lane FSM is forced synchronously to WAIT_STOP and the counter cleared. HSRX_EN/ESC_EN/STOP_STATE fall at the next edge, with no LP_ERR. Synchroniser and filter keep running.
- After LPEnable rises, a lane re-enters STOP only on an accepted 11.
- Lanes are fully independent; simultaneous events on different lanes are handled in parallel.
- HS_PREP counter width is $clog2(D_TERM_EN_TIME+1); the counter saturates, no wrap.
- Reset asserted mid-operation (e.g. in HS_ACTIVE or ESC_ACTIVE) clears all outputs immediately (asynchronously).

Test Plan:
- All tests use NUM_LANES=2, D_TERM_EN_TIME=6, FILTER_LEN=2, LPRX_CLK period 100 ns.
1. Reset 5 cycles, LPEnable=1, both lanes 11 -> STOP_STATE=2'b11 by cycle 4 after LPEnable; all other outputs 0.
2. Lane0: 11 for 10 cyc, 01 for 10, 00 for 30, then 11 ->
   - HSRX_EN[0] rises exactly 6 edges after HS_PREP entry.
   - HSRX_EN[1]=0, ALL_HSRX_EN=0.
   - HSRX_EN[0] falls at the edge the filtered 11 is accepted; STOP_STATE[0]=1.
   - Repeating on both lanes gives ALL_HSRX_EN=1.
3. Lane1: 11, 10, 00, 01, 00 (5 cyc each), then 11 -> ESC_EN[1]=1 after the final 00 is accepted; HSRX_EN[1]=0 throughout; ESC_EN[1]=0 after 11.
4. Lane0 in STOP: 1-cycle 01 glitch -> no change of STOP_STATE; LP_ERR=0. A 2-cycle 01 -> HS_RQST entered (STOP_STATE[0]=0).
5. Lane0: 11 -> 01 -> 10 ->
   - LP_ERR[0] is a single one-cycle pulse and STOP_STATE[0] stays 0 until 11 is restored.
   - 11 -> 00 direct -> also LP_ERR[0].
6. Interruptions:
   - RxRst_n=0 mid HS_ACTIVE -> HSRX_EN=0 before the next edge.
   - LPEnable=0 mid ESC_ACTIVE -> ESC_EN=0 at the next edge with no LP_ERR; a new HS request is honoured only after 11.
